// File: rtl/mem_bus_ctrl.sv
// Bus master that sequences one CPU read/write at a time onto a level-sensitive memory.
// Address, data and direction are settled a cycle before memRq rises and stay put until after it falls.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic              cpuReady,
  output logic              cpuRspValid,
  output logic [DATA_W-1:0] cpuRData,
  output logic              memRq,
  output logic              readNotWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut
);

  localparam int unsigned CNT_W = 4;

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_bus_ctrl: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              mem_rq_d, rnw_d, rsp_d, accept;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_in_d, rdata_d;

  assign cpuReady = (state == IDLE) || (state == HOLD);
  assign accept   = cpuReq & cpuReady;

  // Next-state and next-value decode for every registered output
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    mem_rq_d   = 1'b0;
    rnw_d      = readNotWrite;
    addr_d     = addr;
    data_in_d  = dataIn;
    rdata_d    = cpuRData;
    rsp_d      = (state == HOLD);
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          addr_d    = cpuAddr;
          data_in_d = cpuWData;
          rnw_d     = ~cpuWrite;
          state_d   = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        wait_cnt_d = CNT_W'(WAIT_CYCLES - 1);
        mem_rq_d   = 1'b1;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt == '0) begin
          if (readNotWrite) rdata_d = dataOut;
          state_d = HOLD;
        end else begin
          wait_cnt_d = wait_cnt - CNT_W'(1);
          mem_rq_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      memRq        <= 1'b0;
      readNotWrite <= 1'b1;
      addr         <= '0;
      dataIn       <= '0;
      cpuRspValid  <= 1'b0;
      cpuRData     <= '0;
    end else begin
      state        <= state_d;
      wait_cnt     <= wait_cnt_d;
      memRq        <= mem_rq_d;
      readNotWrite <= rnw_d;
      addr         <= addr_d;
      dataIn       <= data_in_d;
      cpuRspValid  <= rsp_d;
      cpuRData     <= rdata_d;
    end
  end

endmodule
